ssled_reader: RTL and testbench
===============================

# ssled_reader

Receive-side counterpart of the seven-segment glyph encoder. It samples an asynchronous 7-bit active-low segment bus and waits for the pattern to hold still. It then decodes the pattern back to a 4-bit hex value and hands the result downstream on a valid/ready handshake. It sits between the display drive lines and the game-state checker, so the bench and board logic can read back what the display is showing.

## Interface
- `STABLE_CYCLES`, default 4: number of identical consecutive synchronized samples that make a pattern stable. Legal range is at least 1.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `seg_n`  in  7  segment lines, active-low (0 = lit). Bit 0 = a, bit 1 = b, and so on up to bit 6 = g. Asynchronous to `clk`.
- `ready`  in  1  downstream accepts the current result.
- `valid`  out  1  result available. Held until `valid && ready`.
- `value`  out  4  decoded hex digit. Meaningful only when `blank` = 0 and `err` = 0.
- `blank`  out  1  stable pattern was all segments off (7'h7F).
- `err`  out  1  stable pattern matches no glyph and is not blank.

## Operation
- Synchronizer: a two-flop chain on `seg_n` produces `s`. A register `p` holds the previous value of `s`.
- Stability counter `cnt`:
  - `cnt` is `$clog2(STABLE_CYCLES)` bits, minimum 1.
  - When `s != p`, `cnt` clears to 0.
  - Otherwise `cnt` increments, saturating at `STABLE_CYCLES-1`.
  - `stable = (s == p) && (cnt == STABLE_CYCLES-1)`.
- FSM has two states:
  - **TRACK:** if `stable && p != last`, capture `p`, decode it, set `last <= p`, and go to HOLD.
  - **HOLD:** `valid` = 1 and outputs are frozen. On `ready`, go to TRACK. The synchronizer and counter keep running in HOLD.
- Decode (active-low constants, `seg_n[6:0]`):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - On a hit: `value` = index, `blank` = 0, `err` = 0.
  - On 7F: `value` = 0, `blank` = 1, `err` = 0.
  - Anything else: `value` = 0, `blank` = 0, `err` = 1.
- Boundary cases:
  - A glitch shorter than `STABLE_CYCLES` samples is never reported.
  - A pattern that settles back to `last` is never reported again.
  - A pattern that becomes stable during HOLD is reported from TRACK on the cycle after acceptance, provided it is still stable and differs from `last`.
  - `STABLE_CYCLES` = 1: any pattern that differs from `last` and is identical on two successive samples is reported.

## Timing
- Reset values:
  - Outputs: `valid` = 0, `value` = 0, `blank` = 0, `err` = 0.
  - Internal: sync flops, `p` and `last` = 7'h7F; `cnt` = 0; FSM in TRACK.
  - A display that is blank out of reset is never reported.
- Reset asserted mid-handshake drops `valid` immediately, since reset is asynchronous. Pending results are discarded.
- Latency: after a clean step on `seg_n`, `valid` rises on the (`STABLE_CYCLES`+3)th rising edge. With the default, that is edge 7.
- Handshake:
  - `value`, `blank` and `err` are stable for as long as `valid` is high.
  - `valid` falls on the edge after `ready` is sampled high.
  - `ready` asserted while `valid` = 0 has no effect.
  - At least one idle cycle separates consecutive results.

## Structure
- `ssled_pkg` holds:
  - `SEG_BLANK` = 7'h7F.
  - `GLYPH[16]`: the 7-bit active-low constants above, shared with the encoder.
  - `seg_t` typedef (logic [6:0]).
- Sub-module `ssled_glyph_lookup`: purely combinational. Maps `seg_t` to {`hit`, `value[3:0]`} by comparison against `GLYPH`.
- `ssled_reader` instantiates `ssled_glyph_lookup` once, on `p`.

## Test plan
- Reset with `seg_n` = 7F, then hold 7F for 50 cycles -> `valid` never asserts.
- `seg_n` steps 7F -> 30 with `ready` = 1 -> `valid` pulses exactly one cycle at edge 7 with `value` = 3, `blank` = 0, `err` = 0. No further pulses while 30 is held.
- Sweep all 16 glyphs, each held 10 cycles, `ready` = 1 -> 16 results with `value` 0..F in order.
- With `ready` = 0, drive 08, then 7E after 12 cycles -> `value` = A held until `ready`. The cycle after `ready`, an `err` = 1 result follows.
- 40 held, a 2-cycle glitch to 00, back to 40 -> no new result. A 10-cycle hold of 00 -> `value` = 8 reported.
- `reset` asserted while `valid` = 1 -> `valid` = 0 at once. Pattern 7F stable after release -> no result.

Source files
------------

// File: rtl/ssled_pkg.sv
// ssled_pkg: shared seven-segment constants and types.
// Contents: seg_t, SEG_BLANK, GLYPH table (active-low), FSM state type.
package ssled_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Index = hex digit; bit 0 = a ... bit 6 = g, 0 = lit.
   localparam seg_t GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {
      TRACK,
      HOLD
   } state_t;

endpackage

// File: rtl/ssled_reader_if.sv
// ssled_reader_if: segment bus in, decoded result out on valid/ready.
// Ports: seg_n, ready (to reader); valid, value, blank, err (from reader).
interface ssled_reader_if;
   import ssled_pkg::*;

   seg_t       seg_n;
   logic       ready;
   logic       valid;
   logic [3:0] value;
   logic       blank;
   logic       err;

   modport master (
      input  seg_n,
      input  ready,
      output valid,
      output value,
      output blank,
      output err
   );

   modport slave (
      output seg_n,
      output ready,
      input  valid,
      input  value,
      input  blank,
      input  err
   );

endinterface

// File: rtl/ssled_glyph_lookup.sv
// ssled_glyph_lookup: combinational segment pattern to hex digit.
// Ports: seg_i pattern in; hit_o match flag, value_o digit (0 on miss).
module ssled_glyph_lookup
   import ssled_pkg::*;
(
   input  seg_t       seg_i,
   output logic       hit_o,
   output logic [3:0] value_o
);

   always_comb begin
      hit_o   = 1'b0;
      value_o = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (seg_i == GLYPH[i]) begin
            hit_o   = 1'b1;
            value_o = 4'(i);
         end
      end
   end

endmodule

// File: rtl/ssled_reader.sv
// ssled_reader: syncs a segment bus, waits for it to settle, decodes it.
// Ports: clk, reset (async high), bus (seg_n/ready in, valid/value/blank/err out).
module ssled_reader
   import ssled_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic           clk,
   input  logic           reset,
   ssled_reader_if.master bus
);

   localparam int CW =
      (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

   seg_t          sync_q;
   seg_t          s_q;
   seg_t          p_q;
   seg_t          last_q;
   seg_t          last_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   state_t        state_q;
   state_t        state_d;
   logic [3:0]    value_q;
   logic [3:0]    value_d;
   logic          blank_q;
   logic          blank_d;
   logic          err_q;
   logic          err_d;

   logic          hit;
   logic [3:0]    lut_value;
   logic          stable;
   logic          is_blank;

   ssled_glyph_lookup u_lookup (
      .seg_i   (p_q),
      .hit_o   (hit),
      .value_o (lut_value)
   );

   assign stable   = (s_q == p_q) && (cnt_q == CMAX);
   assign is_blank = (p_q == SEG_BLANK);

   always_comb begin
      if (s_q != p_q)
         cnt_d = '0;
      else if (cnt_q != CMAX)
         cnt_d = cnt_q + 1'b1;
      else
         cnt_d = cnt_q;
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      value_d = value_q;
      blank_d = blank_q;
      err_d   = err_q;
      unique case (state_q)
         TRACK: begin
            if (stable && (p_q != last_q)) begin
               state_d = HOLD;
               last_d  = p_q;
               value_d = hit ? lut_value : 4'd0;
               blank_d = is_blank;
               err_d   = !hit && !is_blank;
            end
         end
         HOLD: begin
            if (bus.ready)
               state_d = TRACK;
         end
         default: state_d = TRACK;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= SEG_BLANK;
         s_q     <= SEG_BLANK;
         p_q     <= SEG_BLANK;
         last_q  <= SEG_BLANK;
         cnt_q   <= '0;
         state_q <= TRACK;
         value_q <= 4'd0;
         blank_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync_q  <= bus.seg_n;
         s_q     <= sync_q;
         p_q     <= s_q;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         value_q <= value_d;
         blank_q <= blank_d;
         err_q   <= err_d;
      end
   end

   assign bus.valid = (state_q == HOLD);
   assign bus.value = value_q;
   assign bus.blank = blank_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_ssled_reader.sv
// tb_ssled_reader: directed vectors for ssled_reader.
// Ports: none; drives the interface, checks results against hand tables.
module tb_ssled_reader;

   logic clk = 1'b0;
   logic reset;

   ssled_reader_if bus_if ();

   ssled_reader #(.STABLE_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   logic [6:0] gly [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   int         total = 0;
   int         bad   = 0;
   int         hi_cnt = 0;
   logic [5:0] res_q [$];

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (bus_if.valid)
            hi_cnt++;
         if (bus_if.valid && bus_if.ready)
            res_q.push_back({bus_if.err, bus_if.blank,
                             bus_if.value});
      end
   end

   initial begin
      int         h0;
      int         n0;
      int         first;
      logic [5:0] fv;

      bus_if.seg_n = 7'h7F;
      bus_if.ready = 1'b0;
      reset        = 1'b1;
      tick(3);
      chk("rst_valid", 32'(bus_if.valid), 0);
      chk("rst_value", 32'(bus_if.value), 0);
      chk("rst_blank", 32'(bus_if.blank), 0);
      chk("rst_err", 32'(bus_if.err), 0);
      reset = 1'b0;
      h0 = hi_cnt;
      tick(50);
      chk("idle_blank", 32'(hi_cnt - h0), 0);

      bus_if.ready = 1'b1;
      n0    = res_q.size();
      h0    = hi_cnt;
      first = 0;
      fv    = '0;
      bus_if.seg_n = 7'h30;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (bus_if.valid && first == 0) begin
            first = k;
            fv = {bus_if.err, bus_if.blank, bus_if.value};
         end
      end
      chk("lat_edge", 32'(first), 7);
      chk("lat_res", 32'(fv), 32'h03);
      chk("lat_pulse", 32'(hi_cnt - h0), 1);
      chk("lat_count", 32'(res_q.size() - n0), 1);

      n0 = res_q.size();
      for (int g = 0; g < 16; g++) begin
         bus_if.seg_n = gly[g];
         tick(10);
      end
      chk("sweep_n", 32'(res_q.size() - n0), 16);
      for (int g = 0; g < 16; g++) begin
         if (res_q.size() > n0 + g)
            chk($sformatf("sweep_%0d", g),
                32'(res_q[n0 + g]), 32'(g));
      end

      bus_if.ready = 1'b0;
      bus_if.seg_n = 7'h08;
      tick(12);
      chk("hold_v0", 32'(bus_if.valid), 1);
      chk("hold_a0", 32'(bus_if.value), 10);
      bus_if.seg_n = 7'h7E;
      tick(12);
      chk("hold_v1", 32'(bus_if.valid), 1);
      chk("hold_a1", 32'(bus_if.value), 10);
      chk("hold_e1", 32'(bus_if.err), 0);
      bus_if.ready = 1'b1;
      tick(1);
      chk("acc_drop", 32'(bus_if.valid), 0);
      tick(1);
      chk("err_v", 32'(bus_if.valid), 1);
      chk("err_res", {26'd0, bus_if.err, bus_if.blank,
                      bus_if.value}, 32'h20);
      tick(1);
      chk("err_drop", 32'(bus_if.valid), 0);

      bus_if.seg_n = 7'h40;
      tick(12);
      n0 = res_q.size();
      bus_if.seg_n = 7'h00;
      tick(2);
      bus_if.seg_n = 7'h40;
      tick(15);
      chk("glitch", 32'(res_q.size() - n0), 0);
      bus_if.seg_n = 7'h00;
      tick(10);
      chk("post_n", 32'(res_q.size() - n0), 1);
      if (res_q.size() > n0)
         chk("post_8", 32'(res_q[n0]), 32'h08);

      bus_if.seg_n = 7'h7F;
      tick(10);
      n0 = res_q.size();
      chk("blank_r", 32'(res_q[n0 - 1]), 32'h10);

      bus_if.ready = 1'b0;
      bus_if.seg_n = 7'h19;
      tick(12);
      chk("pre_rst_v", 32'(bus_if.valid), 1);
      chk("pre_rst_4", 32'(bus_if.value), 4);
      #3;
      reset = 1'b1;
      #1;
      chk("rst_async", 32'(bus_if.valid), 0);
      bus_if.seg_n = 7'h7F;
      tick(3);
      reset = 1'b0;
      bus_if.ready = 1'b1;
      h0 = hi_cnt;
      tick(30);
      chk("rst_blank", 32'(hi_cnt - h0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
